gpr_wb_queue: RTL

Write-back queue on the writer side of the general-purpose register file in the multi-cycle CPU. Accepts register write-back requests from the execute/memory stages, buffers up to DEPTH of them in order, and drains one per cycle into the register file's single write port (reg_write / num_write / data_write). Also provides a youngest-match forwarding lookup so rs/rt reads see values still waiting in the queue.

---
 rtl/gpr_wb_queue_pkg.sv | 18 +
 rtl/gpr_wb_fwd_match.sv | 51 +++++
 rtl/gpr_wb_queue.sv | 101 ++++++++++
 3 files changed

// File: rtl/gpr_wb_queue_pkg.sv
// Shared CPU definitions used by the register-file write-back queue.
//   REG_NUM_W  : width of a register number
//   DATA_W     : width of a register value
//   REG_ZERO   : hard-wired zero register; writes to it are discarded
//   wb_entry_t : one pending write-back {num, data}
package gpr_wb_queue_pkg;

    localparam int REG_NUM_W = 5;
    localparam int DATA_W    = 32;

    localparam logic [REG_NUM_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_NUM_W-1:0] num;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/gpr_wb_fwd_match.sv
// Forwarding lookup over the pending write-back entries.
// For each read index the youngest valid entry with a matching register
// number supplies the forwarded value; register zero never hits.
//   entries_i  : raw storage array of the queue
//   head_i     : index of the oldest valid entry
//   count_i    : number of valid entries starting at head_i
//   rs_i, rt_i : read indices
//   a_hit_o/a_fwd_o, b_hit_o/b_fwd_o : match flag and youngest value (0 on miss)
module gpr_wb_fwd_match
    import gpr_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wb_entry_t [DEPTH-1:0] entries_i,
    input  logic [PTR_W-1:0]      head_i,
    input  logic [CNT_W-1:0]      count_i,
    input  logic [REG_NUM_W-1:0]  rs_i,
    input  logic [REG_NUM_W-1:0]  rt_i,
    output logic                  a_hit_o,
    output logic [DATA_W-1:0]     a_fwd_o,
    output logic                  b_hit_o,
    output logic [DATA_W-1:0]     b_fwd_o
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        a_hit_o = 1'b0;
        a_fwd_o = '0;
        b_hit_o = 1'b0;
        b_fwd_o = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (CNT_W'(k) < count_i) begin
                if (rs_i != REG_ZERO && entries_i[idx].num == rs_i) begin
                    a_hit_o = 1'b1;
                    a_fwd_o = entries_i[idx].data;
                end
                if (rt_i != REG_ZERO && entries_i[idx].num == rt_i) begin
                    b_hit_o = 1'b1;
                    b_fwd_o = entries_i[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/gpr_wb_queue.sv
// In-order write-back queue in front of the register file's single write port.
// Buffers up to DEPTH requests, drains one per cycle unless wb_hold_i, and
// forwards the youngest pending value for rs/rt.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o      : request handshake; in_num_i/in_data_i payload
//   wb_hold_i                  : register-file write port busy, no drain
//   reg_write_o/num_write_o/data_write_o : register-file write port
//   rs_i, rt_i                 : forwarding lookup indices
//   a_hit_o/a_fwd_o, b_hit_o/b_fwd_o     : forwarding results
//   count_o, empty_o           : occupancy
module gpr_wb_queue
    import gpr_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [REG_NUM_W-1:0] in_num_i,
    input  logic [DATA_W-1:0]    in_data_i,
    input  logic                 wb_hold_i,
    output logic                 reg_write_o,
    output logic [REG_NUM_W-1:0] num_write_o,
    output logic [DATA_W-1:0]    data_write_o,
    input  logic [REG_NUM_W-1:0] rs_i,
    input  logic [REG_NUM_W-1:0] rt_i,
    output logic                 a_hit_o,
    output logic [DATA_W-1:0]    a_fwd_o,
    output logic                 b_hit_o,
    output logic [DATA_W-1:0]    b_fwd_o,
    output logic [CNT_W-1:0]     count_o,
    output logic                 empty_o
);

    wb_entry_t [DEPTH-1:0] entries_q;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop;

    assign empty_o    = (count_q == '0);
    assign in_ready_o = (count_q < CNT_W'(DEPTH));
    assign count_o    = count_q;

    assign reg_write_o  = !empty_o && !wb_hold_i;
    assign num_write_o  = empty_o ? REG_ZERO : entries_q[head_q].num;
    assign data_write_o = empty_o ? '0 : entries_q[head_q].data;

    // Writes to the zero register complete the handshake but take no slot.
    assign push = in_valid_i && in_ready_o && (in_num_i != REG_ZERO);
    assign pop  = reg_write_o;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            if (push) begin
                entries_q[tail_q] <= {in_num_i, in_data_i};
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    gpr_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .entries_i (entries_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .rs_i      (rs_i),
        .rt_i      (rt_i),
        .a_hit_o   (a_hit_o),
        .a_fwd_o   (a_fwd_o),
        .b_hit_o   (b_hit_o),
        .b_fwd_o   (b_fwd_o)
    );

endmodule
